// File: rtl/countdown_timer.sv
// Game countdown timer: 0..99 s count, pause/restart/bonus,
// BCD digits, warning level and one-cycle time_up pulse.
//
// Ports:
//   clk      system clock (single domain)
//   reset    synchronous active-high reset
//   tick     one-cycle one-second pulse
//   start    one-cycle pulse: load START_SEC, enter RUN
//   pause    level: ticks ignored while high
//   bonus    one-cycle pulse: add BONUS_SEC (saturating)
//   tens     BCD tens digit of count
//   units    BCD units digit of count
//   running  high in RUN
//   expired  high in EXPIRED
//   time_up  one-cycle pulse on RUN->EXPIRED
//   warning  high in RUN while 0 < count <= WARN_SEC
module countdown_timer #(
  parameter int unsigned START_SEC = 60,
  parameter int unsigned BONUS_SEC = 5,
  parameter int unsigned MAX_SEC   = 99,
  parameter int unsigned WARN_SEC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       bonus,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       running,
  output logic       expired,
  output logic       time_up,
  output logic       warning
);

  localparam logic [6:0] START_C = 7'(START_SEC);
  localparam logic [6:0] MAX_C   = 7'(MAX_SEC);
  localparam logic [6:0] WARN_C  = 7'(WARN_SEC);
  localparam logic [7:0] BONUS_W = 8'(BONUS_SEC);
  localparam logic [7:0] MAX_W   = 8'(MAX_SEC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] count_q, count_d;
  logic       time_up_q, time_up_d;

  // Sums are formed 8 bits wide so a bonus near
  // the ceiling cannot wrap before saturation.
  logic [7:0] add_b;
  logic [7:0] add_tb;

  function automatic logic [6:0] sat(
    input logic [7:0] v
  );
    if (v > MAX_W) begin
      return MAX_C;
    end
    return v[6:0];
  endfunction

  always_comb begin
    add_b  = {1'b0, count_q} + BONUS_W;
    add_tb = add_b - 8'd1;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    time_up_d = 1'b0;

    if (start) begin
      // Restart from any state; a held pause
      // takes effect on the following cycle.
      state_d = RUN;
      count_d = START_C;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end

        RUN: begin
          if (pause) begin
            // Pausing drops a coincident tick,
            // but a bonus still lands.
            state_d = PAUSED;
            if (bonus) begin
              count_d = sat(add_b);
            end
          end else if (tick && bonus) begin
            // Net gain is BONUS_SEC-1 >= 0, so
            // this path can never expire.
            count_d = sat(add_tb);
          end else if (bonus) begin
            count_d = sat(add_b);
          end else if (tick) begin
            if (count_q > 7'd1) begin
              count_d = count_q - 7'd1;
            end else begin
              count_d   = 7'd0;
              state_d   = EXPIRED;
              time_up_d = 1'b1;
            end
          end
        end

        PAUSED: begin
          if (bonus) begin
            count_d = sat(add_b);
          end
          if (!pause) begin
            state_d = RUN;
          end
        end

        EXPIRED: begin
          count_d = 7'd0;
        end

        default: begin
          state_d = IDLE;
          count_d = START_C;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= START_C;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      time_up_q <= time_up_d;
    end
  end

  // Binary to BCD by repeated subtraction;
  // count is at most 99 so nine steps suffice.
  logic [6:0] rem;
  logic [3:0] tens_v;

  always_comb begin
    rem    = count_q;
    tens_v = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem    = rem - 7'd10;
        tens_v = tens_v + 4'd1;
      end
    end
  end

  assign tens    = tens_v;
  assign units   = rem[3:0];
  assign running = (state_q == RUN);
  assign expired = (state_q == EXPIRED);
  assign time_up = time_up_q;
  assign warning = (state_q == RUN)
                && (count_q != 7'd0)
                && (count_q <= WARN_C);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer.
// Driver queues expectations; monitor checks them.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic reset, tick, start, pause, bonus;

  logic [3:0] a_tens, a_units;
  logic a_run, a_exp, a_tu, a_warn;
  logic [3:0] b_tens, b_units;
  logic b_run, b_exp, b_tu, b_warn;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  countdown_timer #(
    .START_SEC(3), .BONUS_SEC(5),
    .MAX_SEC(99), .WARN_SEC(2)
  ) u_a (
    .clk(clk), .reset(reset), .tick(tick),
    .start(start), .pause(pause), .bonus(bonus),
    .tens(a_tens), .units(a_units),
    .running(a_run), .expired(a_exp),
    .time_up(a_tu), .warning(a_warn)
  );

  countdown_timer #(
    .START_SEC(97), .BONUS_SEC(5),
    .MAX_SEC(99), .WARN_SEC(2)
  ) u_b (
    .clk(clk), .reset(reset), .tick(tick),
    .start(start), .pause(pause), .bonus(bonus),
    .tens(b_tens), .units(b_units),
    .running(b_run), .expired(b_exp),
    .time_up(b_tu), .warning(b_warn)
  );

  typedef struct {
    string      name;
    int         dut;
    logic [3:0] tens;
    logic [3:0] units;
    logic       run;
    logic       exp;
    logic       tu;
    logic       warn;
  } exp_t;

  exp_t sb[$];

  // One cycle of stimulus plus the expected
  // outputs after the next rising edge.
  task automatic step(
    input string n, input int d,
    input logic r, input logic s,
    input logic t, input logic p,
    input logic b, input int cnt,
    input logic run, input logic ex,
    input logic tu, input logic w
  );
    exp_t e;
    @(negedge clk);
    reset = r; start = s; tick = t;
    pause = p; bonus = b;
    e.name  = n;
    e.dut   = d;
    e.tens  = 4'(cnt / 10);
    e.units = 4'(cnt % 10);
    e.run   = run;
    e.exp   = ex;
    e.tu    = tu;
    e.warn  = w;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [11:0] act, req;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.dut == 0)
          act = {a_tens, a_units, a_run,
                 a_exp, a_tu, a_warn};
        else
          act = {b_tens, b_units, b_run,
                 b_exp, b_tu, b_warn};
        req = {e.tens, e.units, e.run,
               e.exp, e.tu, e.warn};
        checks++;
        if (act !== req) begin
          errors++;
          $display("FAIL %s: got d=%0d%0d r%b e%b t%b w%b want d=%0d%0d r%b e%b t%b w%b",
            e.name, act[11:8], act[7:4], act[3],
            act[2], act[1], act[0], req[11:8],
            req[7:4], req[3], req[2], req[1],
            req[0]);
        end
      end
    end
  end

  initial begin : driver
    int guard;
    reset = 1'b1; start = 1'b0; tick = 1'b0;
    pause = 1'b0; bonus = 1'b0;

    // saturation on the START_SEC=97 instance
    step("b_reset", 1, 1,0,0,0,0, 97, 0,0,0,0);
    step("b_start", 1, 0,1,0,0,0, 97, 1,0,0,0);
    step("b_bon1",  1, 0,0,0,0,1, 99, 1,0,0,0);
    step("b_bon2",  1, 0,0,0,0,1, 99, 1,0,0,0);
    step("b_tb99",  1, 0,0,1,0,1, 99, 1,0,0,0);
    step("b_tick",  1, 0,0,1,0,0, 98, 1,0,0,0);

    // reset state, idle ignores inputs
    step("rst",     0, 1,0,0,0,0, 3, 0,0,0,0);
    step("idle",    0, 0,0,0,0,0, 3, 0,0,0,0);
    step("idle_tk", 0, 0,0,1,1,1, 3, 0,0,0,0);
    // start and three back-to-back ticks
    step("start",   0, 0,1,0,0,0, 3, 1,0,0,0);
    step("tick2",   0, 0,0,1,0,0, 2, 1,0,0,1);
    step("tick1",   0, 0,0,1,0,0, 1, 1,0,0,1);
    step("tick0",   0, 0,0,1,0,0, 0, 0,1,1,0);
    step("exp_hld", 0, 0,0,0,0,0, 0, 0,1,0,0);
    // expired ignores tick/bonus/pause
    step("exp_tb",  0, 0,0,1,1,1, 0, 0,1,0,0);
    step("restart", 0, 0,1,0,0,0, 3, 1,0,0,0);
    // pause holds count across ticks
    step("to2",     0, 0,0,1,0,0, 2, 1,0,0,1);
    step("pause",   0, 0,0,1,1,0, 2, 0,0,0,0);
    for (int i = 0; i < 4; i++)
      step("paused", 0, 0,0,1,1,0, 2, 0,0,0,0);
    step("unpause", 0, 0,0,1,0,0, 2, 1,0,0,1);
    step("resume",  0, 0,0,1,0,0, 1, 1,0,0,1);
    // tick+bonus at count 1 never expires
    step("tb_at1",  0, 0,0,1,0,1, 5, 1,0,0,0);
    // bonus while paused
    step("p_bonus", 0, 0,0,0,1,1, 10, 0,0,0,0);
    step("p_off",   0, 0,0,0,0,0, 10, 1,0,0,0);
    // restart with pause held
    step("st_pause",0, 0,1,0,1,0, 3, 1,0,0,0);
    step("st_pnext",0, 0,0,0,1,0, 3, 0,0,0,0);
    step("st_run",  0, 0,0,0,0,0, 3, 1,0,0,0);
    // reset coincident with tick
    step("to2b",    0, 0,0,1,0,0, 2, 1,0,0,1);
    step("rst_tick",0, 1,0,1,0,0, 3, 0,0,0,0);
    step("post_rst",0, 0,0,1,0,0, 3, 0,0,0,0);
    step("post_bon",0, 0,0,0,0,1, 3, 0,0,0,0);
    step("start2",  0, 0,1,0,0,0, 3, 1,0,0,0);
    step("tick_b",  0, 0,0,1,0,0, 2, 1,0,0,1);

    @(negedge clk);
    tick = 1'b0; start = 1'b0;
    pause = 1'b0; bonus = 1'b0;
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0",
               sb.size());
    end
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
